// File: rtl/sys_timer.sv
`default_nettype none
// ============================================================================
// Module   : sys_timer
// Purpose  : RV32 cycle/time/instret counters with a combinational CSR read
//            port, a 64-bit timecmp register and a registered timer interrupt.
// Revision : 1.0
// ============================================================================
module sys_timer #(
    parameter int unsigned TIME_DIV = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_retired,
    input  logic [1:0]  timer,
    input  logic        upper,
    output logic [31:0] data,
    input  logic        cmp_we,
    input  logic        cmp_upper,
    input  logic [31:0] cmp_wdata,
    output logic        timer_irq
);

    localparam logic [1:0]  SEL_CYCLE     = 2'd0;
    localparam logic [1:0]  SEL_TIME      = 2'd1;
    localparam logic [1:0]  SEL_INSTRET   = 2'd2;
    localparam logic [15:0] PRESCALE_LAST = 16'(TIME_DIV - 1);
    localparam logic [63:0] TIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [63:0] cycle_q,   cycle_d;
    logic [63:0] time_q,    time_d;
    logic [63:0] instret_q, instret_d;
    logic [15:0] prescale_q, prescale_d;
    logic [63:0] timecmp_q, timecmp_d;
    logic        timer_irq_q, timer_irq_d;

    logic        time_tick;
    logic [63:0] read_sel;

    // ------------------------------------------------------------------------
    // Counter next-state
    // ------------------------------------------------------------------------
    always_comb begin
        prescale_d = prescale_q + 16'd1;
        time_tick  = 1'b0;
        if (prescale_q == PRESCALE_LAST) begin
            prescale_d = 16'd0;
            time_tick  = 1'b1;
        end
    end

    // Full-width adds so the low-half carry reaches the upper half in one cycle.
    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        time_d    = time_q;
        instret_d = instret_q;
        if (time_tick) begin
            time_d = time_q + 64'd1;
        end
        if (instr_retired) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Compare register and interrupt
    // ------------------------------------------------------------------------
    always_comb begin
        timecmp_d = timecmp_q;
        if (cmp_we) begin
            if (cmp_upper) begin
                timecmp_d[63:32] = cmp_wdata;
            end else begin
                timecmp_d[31:0]  = cmp_wdata;
            end
        end
    end

    // Evaluated on pre-edge values, so a timecmp write shows up one edge later.
    always_comb begin
        timer_irq_d = (time_q >= timecmp_q);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q     <= 64'd0;
            time_q      <= 64'd0;
            instret_q   <= 64'd0;
            prescale_q  <= 16'd0;
            timecmp_q   <= TIMECMP_RESET;
            timer_irq_q <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            time_q      <= time_d;
            instret_q   <= instret_d;
            prescale_q  <= prescale_d;
            timecmp_q   <= timecmp_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    always_comb begin
        read_sel = 64'd0;
        case (timer)
            SEL_CYCLE:   read_sel = cycle_q;
            SEL_TIME:    read_sel = time_q;
            SEL_INSTRET: read_sel = instret_q;
            default:     read_sel = 64'd0;
        endcase
    end

    assign data      = upper ? read_sel[63:32] : read_sel[31:0];
    assign timer_irq = timer_irq_q;

endmodule
`default_nettype wire
